// File: rtl/pipe_t.sv
// Pipe record type shared by the flappy_bird game logic; storage blocks treat it as opaque.
package pipe_pkg;
  typedef struct packed {
    logic [9:0] x;
    logic [7:0] gap_y;
  } pipe_t;
endpackage

// File: rtl/pipes_list.sv
// Bounded insertion-ordered pipe list with a single-pass rewrite/drop walk that compacts in place.
// Define PIPES_LIST_ASSERTIONS_EN to compile in simulation-only protocol checks.
module pipes_list
  import pipe_pkg::*;
#(
  parameter int CAPACITY = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic [4:0] count,
  input  logic       insert_en,
  input  pipe_t      insert_data,
  input  logic       iter_start,
  output logic       iter_done,
  output pipe_t      iter_out,
  input  pipe_t      iter_in,
  input  logic       iter_remove
);
  localparam int AW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;

  typedef enum logic {IDLE, ITER} state_t;

  state_t     state, state_d;
  logic [4:0] count_d, rd, rd_d, wr, wr_d, n, n_d;
  logic       mem_we;
  logic [AW-1:0] mem_wa;
  pipe_t      mem_wd;
  pipe_t      mem [CAPACITY];

  always_comb begin
    state_d   = state;
    count_d   = count;
    rd_d      = rd;
    wr_d      = wr;
    n_d       = n;
    mem_we    = 1'b0;
    mem_wa    = count[AW-1:0];
    mem_wd    = insert_data;
    iter_done = 1'b1;
    iter_out  = '0;
    case (state)
      IDLE: begin
        // iter_start wins over a same-cycle insert
        if (iter_start) begin
          if (count != 5'd0) begin
            n_d     = count;
            rd_d    = 5'd0;
            wr_d    = 5'd0;
            state_d = ITER;
          end
        end else if (insert_en && count < 5'(CAPACITY)) begin
          mem_we  = 1'b1;
          count_d = count + 5'd1;
        end
      end
      ITER: begin
        iter_done = 1'b0;
        iter_out  = mem[rd[AW-1:0]];
        rd_d      = rd + 5'd1;
        // wr trails rd, so the write never clobbers an unvisited element
        if (!iter_remove) begin
          mem_we = 1'b1;
          mem_wa = wr[AW-1:0];
          mem_wd = iter_in;
          wr_d   = wr + 5'd1;
        end
        if (rd == n - 5'd1) begin
          count_d = wr_d;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 5'd0;
      rd    <= 5'd0;
      wr    <= 5'd0;
      n     <= 5'd0;
    end else if (ce) begin
      state <= state_d;
      count <= count_d;
      rd    <= rd_d;
      wr    <= wr_d;
      n     <= n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ce && mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef PIPES_LIST_ASSERTIONS_EN
  always_ff @(posedge clk) begin
    if (!rst && ce) begin
      if (count > 5'(CAPACITY)) $error("pipes_list: count %0d exceeds capacity", count);
      if (insert_en && state == ITER) $error("pipes_list: insert during iteration");
      if (insert_en && state == IDLE && count == 5'(CAPACITY)) $error("pipes_list: insert while full");
      if (iter_start && state == ITER) $error("pipes_list: iter_start during iteration");
      if (wr > rd) $error("pipes_list: write index %0d ahead of read index %0d", wr, rd);
    end
  end
`else
  // protocol checks not compiled in this build
`endif
endmodule

// File: tb/tb_pipes_list.sv
// Scoreboard bench for pipes_list: a queue model of the list supplies every expected visit and count.
module tb_pipes_list;
  import pipe_pkg::*;
  localparam int CAP = 16;
  localparam int PW  = $bits(pipe_t);

  logic       clk = 1'b0;
  logic       rst, ce, insert_en, iter_start, iter_remove, iter_done;
  logic [4:0] count;
  pipe_t      insert_data, iter_in, iter_out;
  logic [PW-1:0] out_bits;

  int n_cmp = 0;
  int n_bad = 0;
  int model[$];
  int sb[$];

  assign out_bits = iter_out;

  pipes_list #(.CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst), .ce(ce), .count(count),
    .insert_en(insert_en), .insert_data(insert_data),
    .iter_start(iter_start), .iter_done(iter_done), .iter_out(iter_out),
    .iter_in(iter_in), .iter_remove(iter_remove)
  );

  always #5 clk = ~clk;

  function automatic pipe_t mk(input int v);
    logic [PW-1:0] t;
    t = v[PW-1:0];
    return pipe_t'(t);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_insert(input int v);
    insert_en   = 1'b1;
    insert_data = mk(v);
    tick();
    insert_en = 1'b0;
    if (model.size() < CAP) model.push_back(v);
  endtask

  // mode 1 rewrites each element as value+1; noise drives inputs that must be ignored
  task automatic do_pass(input int mode, input bit rm_first, input int stall_at, input bit noise);
    int nn;
    int e;
    int newm[$];
    nn = model.size();
    foreach (model[i]) sb.push_back(model[i]);
    iter_start  = 1'b1;
    insert_en   = noise;
    insert_data = mk(55);
    tick();
    iter_start = 1'b0;
    insert_en  = 1'b0;
    for (int i = 0; i < nn; i++) begin
      if (i == stall_at) begin
        ce = 1'b0; iter_remove = 1'b1; iter_in = mk(99); insert_en = 1'b1;
        tick(); tick();
        ce = 1'b1; iter_remove = 1'b0; insert_en = 1'b0;
      end
      e = sb.pop_front();
      n_cmp++;
      if (iter_done !== 1'b0) begin
        n_bad++;
        $display("FAIL pass_busy[%0d]: iter_done=%0b want 0", i, iter_done);
      end
      n_cmp++;
      if (out_bits !== mk(e)) begin
        n_bad++;
        $display("FAIL pass_visit[%0d]: iter_out=%0d want %0d", i, out_bits, e);
      end
      iter_in     = mk(mode == 1 ? e + 1 : e);
      iter_remove = rm_first && (i == 0);
      insert_en   = noise;
      iter_start  = noise;
      insert_data = mk(77);
      if (!iter_remove) newm.push_back(mode == 1 ? e + 1 : e);
      tick();
    end
    insert_en = 1'b0; iter_start = 1'b0; iter_remove = 1'b0;
    model = newm;
    n_cmp++;
    if (iter_done !== 1'b1) begin
      n_bad++;
      $display("FAIL pass_end_done: iter_done=%0b want 1", iter_done);
    end
    n_cmp++;
    if (count !== 5'(model.size())) begin
      n_bad++;
      $display("FAIL pass_end_count: count=%0d want %0d", count, model.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model.delete(); sb.delete();
    n_cmp++;
    if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: count=%0d want 0", count); end
    n_cmp++;
    if (iter_done !== 1'b1) begin n_bad++; $display("FAIL reset_done: iter_done=%0b want 1", iter_done); end
    n_cmp++;
    if (out_bits !== '0) begin n_bad++; $display("FAIL reset_out: iter_out=%0d want 0", out_bits); end
  endtask

  task automatic test_insert;
    for (int v = 1; v <= 4; v++) do_insert(v);
    n_cmp++;
    if (count !== 5'd4) begin n_bad++; $display("FAIL insert_count: count=%0d want 4", count); end
    n_cmp++;
    if (iter_done !== 1'b1) begin n_bad++; $display("FAIL insert_done: iter_done=%0b want 1", iter_done); end
  endtask

  task automatic test_pass_identity;
    for (int p = 0; p < 5; p++) do_pass(0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_pass_increment;
    for (int p = 0; p < 4; p++) do_pass(1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_remove;
    for (int p = 0; p < 4; p++) do_pass(0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_empty_start;
    iter_start = 1'b1;
    tick();
    iter_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (iter_done !== 1'b1) begin n_bad++; $display("FAIL empty_done[%0d]: iter_done=%0b want 1", c, iter_done); end
      n_cmp++;
      if (count !== 5'd0) begin n_bad++; $display("FAIL empty_count[%0d]: count=%0d want 0", c, count); end
      tick();
    end
  endtask

  task automatic test_full;
    for (int v = 1; v <= CAP + 1; v++) do_insert(v);
    n_cmp++;
    if (count !== 5'(CAP)) begin n_bad++; $display("FAIL full_count: count=%0d want %0d", count, CAP); end
    do_pass(0, 1'b0, 3, 1'b1);
  endtask

  task automatic test_reset_mid_pass;
    iter_start = 1'b1;
    tick();
    iter_start  = 1'b0;
    iter_in     = mk(model[0]);
    iter_remove = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model.delete(); sb.delete();
    n_cmp++;
    if (count !== 5'd0) begin n_bad++; $display("FAIL abort_count: count=%0d want 0", count); end
    n_cmp++;
    if (iter_done !== 1'b1) begin n_bad++; $display("FAIL abort_done: iter_done=%0b want 1", iter_done); end
    n_cmp++;
    if (out_bits !== '0) begin n_bad++; $display("FAIL abort_out: iter_out=%0d want 0", out_bits); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; insert_en = 1'b0; iter_start = 1'b0; iter_remove = 1'b0;
    insert_data = '0; iter_in = '0;
    test_reset();
    test_insert();
    test_pass_identity();
    test_pass_increment();
    test_remove();
    test_empty_start();
    test_full();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipes_list.md
# pipes_list

Bounded, insertion-ordered store of active pipe records for the flappy_bird game logic. The game inserts new pipes at the tail and periodically walks the whole list once. During that walk each element can be rewritten, for example to move it, or dropped, for example when it is off-screen. Surviving elements are compacted in place and keep their order.

## Interface
- CAPACITY, 16, maximum number of stored pipes; 1..31 so it fits in `count`.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds and all inputs are ignored.
- count  out  5  number of stored pipes.
- insert_en  in  1  append `insert_data` at the tail this cycle.
- insert_data  in  $bits(pipe_t)  element to append.
- iter_start  in  1  begin one iteration pass.
- iter_done  out  1  high when no pass is in progress.
- iter_out  out  $bits(pipe_t)  element currently visited.
- iter_in  in  $bits(pipe_t)  replacement value for the visited element.
- iter_remove  in  1  drop the visited element instead of writing it back.
- `pipe_t` is the packed type from pipe_t.sv. The block never interprets its fields; it only stores whole elements.

## Operation
- Storage: array `mem[0..CAPACITY-1]`. Valid elements occupy `mem[0..count-1]` in insertion order.
- States:
  - IDLE: `iter_done`=1.
  - ITER: `iter_done`=0.
- Registers: `rd` (read index), `wr` (write index), `n` (count snapshot taken at start).
- In IDLE with `iter_start`=1:
  - If `count`>0: `n`<=`count`, `rd`<=0, `wr`<=0, go to ITER.
  - If `count`=0: stay in IDLE.
  - A simultaneous `insert_en` is dropped; `iter_start` has priority.
- In IDLE with `insert_en`=1 and `iter_start`=0:
  - If `count`<CAPACITY: `mem[count]`<=`insert_data`, `count`++.
  - If `count`=CAPACITY: the insert is silently dropped.
- In ITER, every `ce` cycle visits element `rd`, with `iter_out`=`mem[rd]` (combinational):
  - If `iter_remove`=0: `mem[wr]`<=`iter_in`, `wr`++.
  - If `iter_remove`=1: nothing is written and `wr` is unchanged.
  - `rd`++ in both cases.
  - On the cycle where `rd`=`n`-1 (the last element): `count`<=final `wr` (including this cycle's write), then go to IDLE.
- `wr`≤`rd` always holds, so compaction never overwrites an unread element.
- Ignored inputs:
  - `insert_en` is ignored during ITER.
  - `iter_start` is ignored during ITER.
  - `iter_remove` and `iter_in` are ignored in IDLE.
- `iter_out` is 0 in IDLE.

## Timing
- Reset values: `count`=0, `iter_done`=1, `iter_out`=0, state=IDLE. Array contents are don't-care.
- Insert: `count` updates on the edge that samples `insert_en`. Back-to-back inserts are accepted one per cycle.
- Pass over N elements:
  - `iter_start` is sampled at edge 0.
  - Elements 0..N-1 are presented in cycles 1..N.
  - `iter_in` and `iter_remove` are sampled at the same edge that ends each element's cycle.
  - `iter_done` rises, and the new `count` is visible, right after edge N.
- Pass length is fixed by `n`, independent of removals.
- Empty list: `iter_done` never drops.
- `ce`=0 mid-pass stretches the current element's cycle.
- `rst` mid-pass aborts the pass and clears the list.

## Configuration
- PIPES_LIST_ASSERTIONS_EN defined: simulation-only immediate assertions are compiled in. Each one reports `$error`:
  - `count`>CAPACITY;
  - `insert_en` while full, or while in ITER;
  - `iter_start` while in ITER;
  - `wr`>`rd`.
- Undefined: no assertion code exists; functional behaviour is identical.

## Test plan
- Reset, then insert 1,2,3,4 on consecutive cycles -> `count`=4, `iter_done`=1.
- Pass with `iter_in`=`iter_out` -> `iter_out` sequence 1,2,3,4; `iter_done` high 4 cycles after start; `count`=4; repeating 5 times gives the same result.
- Four passes with `iter_in`=`iter_out`+1 -> the next pass shows 5,6,7,8.
- Four passes, each with `iter_remove`=1 on the first visited cycle only -> `count` goes 3,2,1,0; remaining order is preserved (e.g. 6,7,8 after the first pass).
- `iter_start` with `count`=0 -> `iter_done` stays 1 and `count` stays 0.
- 17 inserts with CAPACITY=16 -> `count`=16; the 17th is dropped; the assertion fires when PIPES_LIST_ASSERTIONS_EN is defined.
